nonce_sequencer: RTL and testbench

- Upstream control stage for the concatenator/hash pair in the mining datapath.
- Latches a 12-byte block entry and an 8-bit target, then issues nonces one at a time to the concatenator/hash path.
- Checks each returned 3-byte hash against the target and stops on the first hit or when the nonce range is exhausted.
- Reports the winning nonce, its hash and the attempt count.

---
 rtl/nonce_sequencer_if.sv | 25 ++
 rtl/nonce_sequencer.sv | 98 +++++++++
 tb/tb_nonce_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/nonce_sequencer_if.sv
// nonce_sequencer_if: request/response bundle between the nonce sequencer and its host/hash path.
interface nonce_sequencer_if;
  logic        start;
  logic [95:0] entry_12;
  logic [7:0]  target;
  logic [23:0] hash_in;
  logic        hash_valid;
  logic [95:0] block_entry;
  logic [31:0] nonce;
  logic        hash_req;
  logic        busy;
  logic        found;
  logic        exhausted;
  logic [31:0] nonce_found;
  logic [23:0] hash_found;
  logic [31:0] attempts;
  modport master (
    output start, entry_12, target, hash_in, hash_valid,
    input  block_entry, nonce, hash_req, busy, found, exhausted, nonce_found, hash_found, attempts
  );
  modport slave (
    input  start, entry_12, target, hash_in, hash_valid,
    output block_entry, nonce, hash_req, busy, found, exhausted, nonce_found, hash_found, attempts
  );
endinterface

// File: rtl/nonce_sequencer.sv
// nonce_sequencer: issues nonces to the hash path and stops on the first hash below target or on range exhaustion.
module nonce_sequencer #(
  parameter logic [31:0] NONCE_START  = 32'h0000_0000,
  parameter logic [31:0] NONCE_MAX    = 32'hFFFF_FFFF,
  parameter int          WAIT_TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  nonce_sequencer_if.slave bus
);
  localparam int TW = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FOUND, EXHAUSTED} state_t;
  state_t        state_q;
  logic [95:0]   block_entry_q;
  logic [7:0]    target_q;
  logic [31:0]   nonce_q, nonce_found_q, attempts_q, attempts_d;
  logic [23:0]   hash_found_q;
  logic [TW-1:0] cnt_q;
  logic          hash_req_q, busy_q, found_q, exhausted_q, hit_d;
  always_comb begin
    attempts_d = (attempts_q == 32'hFFFF_FFFF) ? attempts_q : attempts_q + 32'd1;
    hit_d      = (bus.hash_in[23:16] < target_q) && (bus.hash_in[15:8] < target_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      block_entry_q <= '0;
      target_q      <= '0;
      nonce_q       <= '0;
      nonce_found_q <= '0;
      hash_found_q  <= '0;
      attempts_q    <= '0;
      cnt_q         <= '0;
      hash_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
    end else begin
      case (state_q)
        ISSUE: begin
          hash_req_q <= 1'b0;
          cnt_q      <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (bus.hash_valid) begin
            attempts_q <= attempts_d;
            if (hit_d) begin
              state_q       <= FOUND;
              found_q       <= 1'b1;
              busy_q        <= 1'b0;
              nonce_found_q <= nonce_q;
              hash_found_q  <= bus.hash_in;
            end else if (nonce_q == NONCE_MAX) begin
              state_q     <= EXHAUSTED;
              exhausted_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              nonce_q    <= nonce_q + 32'd1;
              state_q    <= ISSUE;
              hash_req_q <= 1'b1;
            end
          end else if (cnt_q == TW'(WAIT_TIMEOUT - 2)) begin
            // counter would reach WAIT_TIMEOUT-1 this edge: re-issue the same nonce
            state_q    <= ISSUE;
            hash_req_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (bus.start) begin
            block_entry_q <= bus.entry_12;
            target_q      <= bus.target;
            nonce_q       <= NONCE_START;
            attempts_q    <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            nonce_found_q <= '0;
            hash_found_q  <= '0;
            busy_q        <= 1'b1;
            hash_req_q    <= 1'b1;
            state_q       <= ISSUE;
          end
        end
      endcase
    end
  end
  assign bus.block_entry = block_entry_q;
  assign bus.nonce       = nonce_q;
  assign bus.hash_req    = hash_req_q;
  assign bus.busy        = busy_q;
  assign bus.found       = found_q;
  assign bus.exhausted   = exhausted_q;
  assign bus.nonce_found = nonce_found_q;
  assign bus.hash_found  = hash_found_q;
  assign bus.attempts    = attempts_q;
endmodule

// File: tb/tb_nonce_sequencer.sv
// tb_nonce_sequencer: directed vectors for hit evaluation plus hand sequences for timeout, exhaustion and start handling.
module tb_nonce_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  nonce_sequencer_if a_if ();
  nonce_sequencer_if b_if ();
  nonce_sequencer #(.NONCE_START(32'd0), .NONCE_MAX(32'hFFFF_FFFF), .WAIT_TIMEOUT(4)) dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));
  nonce_sequencer #(.NONCE_START(32'd5), .NONCE_MAX(32'd7), .WAIT_TIMEOUT(16)) dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0]  target;
    logic [23:0] hash;
    logic        hit;
  } vec_t;
  vec_t vecs [9];
  localparam logic [95:0] ENTRY_A = 96'h0C0B0A09_08070605_04030201;
  localparam logic [95:0] ENTRY_B = 96'hA5A5A5A5_DEADBEEF_12345678;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_req(input bit sel_b);
    int n;
    n = 0;
    while (!(sel_b ? b_if.hash_req : a_if.hash_req) && n < 20) begin
      tick();
      n++;
    end
    chk("hash_req_seen", sel_b ? b_if.hash_req : a_if.hash_req, 1'b1);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic start_a(input logic [95:0] e, input logic [7:0] t);
    a_if.entry_12 = e;
    a_if.target   = t;
    a_if.start    = 1'b1;
    tick();
    a_if.start = 1'b0;
  endtask
  task automatic give_a(input logic [23:0] h);
    a_if.hash_in    = h;
    a_if.hash_valid = 1'b1;
    tick();
    a_if.hash_valid = 1'b0;
  endtask
  initial begin
    vecs[0] = '{8'h40, 24'h10_20_FF, 1'b1};
    vecs[1] = '{8'h10, 24'h10_00_00, 1'b0};
    vecs[2] = '{8'h10, 24'h00_10_00, 1'b0};
    vecs[3] = '{8'h10, 24'h0F_0F_FF, 1'b1};
    vecs[4] = '{8'h00, 24'h00_00_00, 1'b0};
    vecs[5] = '{8'hFF, 24'hFE_FE_FF, 1'b1};
    vecs[6] = '{8'hFF, 24'hFF_00_00, 1'b0};
    vecs[7] = '{8'h01, 24'h00_00_FF, 1'b1};
    vecs[8] = '{8'h80, 24'h7F_80_00, 1'b0};
    a_if.start = 0; a_if.entry_12 = '0; a_if.target = '0; a_if.hash_in = '0; a_if.hash_valid = 0;
    b_if.start = 0; b_if.entry_12 = '0; b_if.target = '0; b_if.hash_in = '0; b_if.hash_valid = 0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", a_if.busy, 1'b0);
    chk("rst_found", a_if.found, 1'b0);
    chk("rst_nonce", a_if.nonce, 32'd0);
    chk("rst_attempts", a_if.attempts, 32'd0);
    chk("rst_block_entry", a_if.block_entry, 96'd0);
    chk("rst_hash_req", a_if.hash_req, 1'b0);
    // immediate hit
    start_a(ENTRY_A, 8'h40);
    chk("imm_hash_req", a_if.hash_req, 1'b1);
    chk("imm_busy", a_if.busy, 1'b1);
    tick();
    chk("imm_req_pulse", a_if.hash_req, 1'b0);
    give_a(24'h10_20_FF);
    chk("imm_found", a_if.found, 1'b1);
    chk("imm_busy_done", a_if.busy, 1'b0);
    chk("imm_nonce_found", a_if.nonce_found, 32'd0);
    chk("imm_hash_found", a_if.hash_found, 24'h1020FF);
    chk("imm_attempts", a_if.attempts, 32'd1);
    chk("imm_block_entry", a_if.block_entry, ENTRY_A);
    // restart from FOUND, hit on third nonce
    start_a(ENTRY_B, 8'h10);
    chk("t3_found_clr", a_if.found, 1'b0);
    chk("t3_nf_clr", a_if.nonce_found, 32'd0);
    chk("t3_hf_clr", a_if.hash_found, 24'd0);
    chk("t3_attempts_clr", a_if.attempts, 32'd0);
    chk("t3_block_entry", a_if.block_entry, ENTRY_B);
    for (int i = 0; i < 3; i++) begin
      wait_req(1'b0);
      chk("t3_nonce", a_if.nonce, 32'(i));
      tick();
      give_a(i == 0 ? 24'h05_90_00 : i == 1 ? 24'h90_05_00 : 24'h0F_0F_AA);
    end
    chk("t3_found", a_if.found, 1'b1);
    chk("t3_nonce_found", a_if.nonce_found, 32'd2);
    chk("t3_hash_found", a_if.hash_found, 24'h0F0FAA);
    chk("t3_attempts", a_if.attempts, 32'd3);
    // hit-evaluation table, one fresh search per vector
    for (int v = 0; v < 9; v++) begin
      do_reset();
      start_a(ENTRY_A, vecs[v].target);
      tick();
      give_a(vecs[v].hash);
      chk("vec_found", a_if.found, vecs[v].hit);
      chk("vec_busy", a_if.busy, !vecs[v].hit);
      chk("vec_attempts", a_if.attempts, 32'd1);
      chk("vec_nonce", a_if.nonce, vecs[v].hit ? 32'd0 : 32'd1);
    end
    // exhaustion on the 5..7 instance
    do_reset();
    b_if.entry_12 = ENTRY_B;
    b_if.target = 8'h20;
    b_if.start = 1'b1;
    tick();
    b_if.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_req(1'b1);
      chk("ex_nonce", b_if.nonce, 32'd5 + 32'(i));
      tick();
      b_if.hash_in = 24'hFFFFFF;
      b_if.hash_valid = 1'b1;
      tick();
      b_if.hash_valid = 1'b0;
    end
    chk("ex_exhausted", b_if.exhausted, 1'b1);
    chk("ex_found", b_if.found, 1'b0);
    chk("ex_nonce_hold", b_if.nonce, 32'd7);
    chk("ex_attempts", b_if.attempts, 32'd3);
    chk("ex_busy", b_if.busy, 1'b0);
    tick();
    chk("ex_held", b_if.exhausted, 1'b1);
    chk("ex_no_req", b_if.hash_req, 1'b0);
    // timeout re-issue, then valid during ISSUE is ignored
    do_reset();
    start_a(ENTRY_A, 8'h40);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_no_req", a_if.hash_req, 1'b0);
    end
    tick();
    chk("to_reissue", a_if.hash_req, 1'b1);
    chk("to_nonce", a_if.nonce, 32'd0);
    chk("to_attempts", a_if.attempts, 32'd0);
    give_a(24'h01_01_01);
    chk("to_issue_ignore", a_if.found, 1'b0);
    chk("to_issue_att", a_if.attempts, 32'd0);
    give_a(24'h01_01_01);
    chk("to_found", a_if.found, 1'b1);
    chk("to_nonce_found", a_if.nonce_found, 32'd0);
    chk("to_attempts_1", a_if.attempts, 32'd1);
    // start while busy is ignored
    start_a(ENTRY_A, 8'h40);
    tick();
    start_a(ENTRY_B, 8'h80);
    chk("busy_block_entry", a_if.block_entry, ENTRY_A);
    chk("busy_still", a_if.busy, 1'b1);
    chk("busy_no_req", a_if.hash_req, 1'b0);
    give_a(24'h50_00_00);
    chk("busy_target_kept", a_if.found, 1'b0);
    // async reset mid-WAIT with start held high
    wait_req(1'b0);
    tick();
    a_if.start = 1'b1;
    a_if.entry_12 = ENTRY_B;
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", a_if.busy, 1'b0);
    chk("arst_nonce", a_if.nonce, 32'd0);
    chk("arst_attempts", a_if.attempts, 32'd0);
    chk("arst_block_entry", a_if.block_entry, 96'd0);
    tick();
    chk("arst_start_ignored", a_if.busy, 1'b0);
    chk("arst_req", a_if.hash_req, 1'b0);
    a_if.start = 1'b0;
    reset = 1'b0;
    tick();
    chk("arst_idle", a_if.busy, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
